req_encoder: RTL

Sequential 8-to-3 event encoder: the inverse of the 3-to-8 enable decoder. It captures one-hot or multi-hot request bits into a pending register and emits them one at a time as a 3-bit index with a valid/ready handshake. It sits between event sources such as interrupt or status lines and a consumer that accepts one index per transfer.

---
 rtl/req_encoder_pkg.sv | 10 +
 rtl/pri_enc8.sv | 27 ++
 rtl/req_encoder.sv | 92 +++++++++
 3 files changed

// File: rtl/req_encoder_pkg.sv
// Shared types and sizes for the req_encoder block (8-to-3 sequential event encoder).
package req_encoder_pkg;

  localparam int N      = 8;
  localparam int CODE_W = $clog2(N);

  typedef logic [N-1:0]      req_vec_t;
  typedef logic [CODE_W-1:0] code_t;

endpackage

// File: rtl/pri_enc8.sv
// Combinational wrapping priority encoder: first set bit of vec_i at or after start_i.
module pri_enc8
  import req_encoder_pkg::*;
(
  input  logic [N-1:0]      vec_i,
  input  logic [CODE_W-1:0] start_i,
  output logic [CODE_W-1:0] idx_o,
  output logic              any_o
);

  code_t pos;

  // Scan from the farthest offset back to start_i so the nearest set bit is written last.
  always_comb begin
    idx_o = '0;
    pos   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      pos = start_i + code_t'(i);
      if (vec_i[pos]) begin
        idx_o = pos;
      end
    end
  end

  assign any_o = |vec_i;

endmodule

// File: rtl/req_encoder.sv
// Captures request bits into a pending set and hands them out one index per valid/ready transfer.
// Define RR_PRIORITY_EN for round-robin selection; otherwise the lowest pending index wins.
module req_encoder
  import req_encoder_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [N-1:0]      req,
  input  logic              out_ready,
  output logic [CODE_W-1:0] code,
  output logic              valid,
  output logic              overflow
);

  req_vec_t pending_q, pending_d;
  req_vec_t set_vec, grant_vec;
  code_t    code_q, code_d;
  logic     valid_q, valid_d;
  logic     overflow_q, overflow_d;
  code_t    sel, start;
  logic     any, load;

`ifdef RR_PRIORITY_EN
  code_t rr_ptr_q, rr_ptr_d;

  // The search begins one past the last granted line; the 3-bit add wraps 7 to 0.
  assign start = rr_ptr_q + code_t'(1);
`else
  assign start = '0;
`endif

  pri_enc8 u_pri_enc8 (
    .vec_i   (pending_q),
    .start_i (start),
    .idx_o   (sel),
    .any_o   (any)
  );

  always_comb begin
    set_vec    = en ? req : '0;
    load       = (!valid_q || out_ready) && any;
    grant_vec  = load ? (req_vec_t'(1) << sel) : '0;
    // A bit set again while still pending is lost; a bit granted this cycle may be re-armed.
    pending_d  = (pending_q & ~grant_vec) | set_vec;
    overflow_d = |(set_vec & pending_q & ~grant_vec);
    code_d     = code_q;
    valid_d    = valid_q;
    if (load) begin
      code_d  = sel;
      valid_d = 1'b1;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

`ifdef RR_PRIORITY_EN
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (load) begin
      rr_ptr_d = sel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= code_t'(N - 1);
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q  <= '0;
      code_q     <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      code_q     <= code_d;
      valid_q    <= valid_d;
      overflow_q <= overflow_d;
    end
  end

  assign code     = code_q;
  assign valid    = valid_q;
  assign overflow = overflow_q;

endmodule
